// File: rtl/dm_responder.sv
// dm_responder: the memory side of the CPU data-memory port, modelling a slow
// backing store with a fixed access latency. While an access is in flight,
// stall is held high so the pipeline keeps its EX/MEM request stable.
//
// Ports:
//   clk       - clock; all state changes on posedge
//   rst_n     - asynchronous active-low reset (array contents are kept)
//   addr      - word address; only addr[AW-1:0] is used (upper bits alias)
//   re, we    - read / write request; we wins when both are high
//   wrt_data  - write data
//   rd_data   - registered read data; changes only when a read completes
//   stall     - combinational; high while the current access is incomplete
//
// Handshake: a request (re|we) is accepted in IDLE and the CPU must hold it
// while stall is high. The cycle in which stall drops is the completion cycle
// (rd_data valid); the CPU advances on that cycle's closing edge. A request
// still present in the completion cycle is not restarted.
//
// Parameters: AW (word-address width, depth 2**AW), LATENCY (1..15 cycles of
// stall per access).
//
// Optional build macro DM_POSTED_WRITE_EN: adds a one-entry posted-write
// buffer. A plain write that finds the buffer empty completes with no stall
// and commits to the array LATENCY cycles later; any request that arrives
// while the buffer holds data stalls until that commit.
module dm_responder #(
  parameter int AW      = 8,
  parameter int LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] addr,
  input  logic        re,
  input  logic        we,
  input  logic [15:0] wrt_data,
  output logic [15:0] rd_data,
  output logic        stall
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state, state_next;
  logic [3:0]    cnt, cnt_next;
  logic [15:0]   mem [0:(1<<AW)-1];

  logic [AW-1:0] lat_idx;
  logic [15:0]   lat_data;
  logic          lat_write;
  logic          lat_rd_also;

  logic          req;
  logic          start;
  logic          post;
  logic          blocked;

  logic          acc_fire;
  logic [AW-1:0] acc_idx;
  logic [15:0]   acc_data;
  logic          acc_write;
  logic          acc_rd_also;

  logic          mem_we;
  logic [AW-1:0] mem_idx;
  logic [15:0]   mem_data;

  // Upper address bits are deliberately ignored (aliasing).
  logic          addr_unused;
  assign addr_unused = ^addr[15:AW];

  assign req = re | we;

`ifdef DM_POSTED_WRITE_EN
  logic          buf_valid;
  logic [AW-1:0] buf_idx;
  logic [15:0]   buf_data;
  logic [3:0]    drain;
  logic          buf_commit;
  logic          direct_post;

  // A plain write (not re=we=1) into an empty buffer is posted.
  assign post        = ~buf_valid & we & ~re;
  assign blocked     = buf_valid;
  assign buf_commit  = buf_valid & (drain == 4'd0);
  // With a one-cycle latency the posted write lands on the capture edge.
  assign direct_post = (state == IDLE) & post & (LATENCY == 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid <= 1'b0;
      buf_idx   <= '0;
      buf_data  <= '0;
      drain     <= '0;
    end else if (buf_valid) begin
      if (drain == 4'd0) buf_valid <= 1'b0;
      else               drain     <= drain - 4'd1;
    end else if ((state == IDLE) && post && (LATENCY > 1)) begin
      buf_valid <= 1'b1;
      buf_idx   <= addr[AW-1:0];
      buf_data  <= wrt_data;
      drain     <= 4'(LATENCY - 2);
    end
  end
`else
  assign post    = 1'b0;
  assign blocked = 1'b0;
`endif

  assign start = (state == IDLE) & req & ~blocked & ~post;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    stall      = 1'b0;
    case (state)
      IDLE: begin
        stall = req & ~post;
        if (start) begin
          if (LATENCY == 1) begin
            state_next = DONE;
          end else begin
            state_next = BUSY;
            cnt_next   = 4'(LATENCY - 2);
          end
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (cnt == 4'd0) state_next = DONE;
        else             cnt_next   = cnt - 4'd1;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request capture; inputs seen during BUSY are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_idx     <= '0;
      lat_data    <= '0;
      lat_write   <= 1'b0;
      lat_rd_also <= 1'b0;
    end else if (start) begin
      lat_idx     <= addr[AW-1:0];
      lat_data    <= wrt_data;
      lat_write   <= we;
      lat_rd_also <= re;
    end
  end

  // The access happens on the edge that enters DONE. For LATENCY=1 that edge
  // closes the IDLE cycle, so the live inputs are used directly.
  assign acc_fire    = (start & (LATENCY == 1)) | ((state == BUSY) & (cnt == 4'd0));
  assign acc_idx     = (state == IDLE) ? addr[AW-1:0] : lat_idx;
  assign acc_data    = (state == IDLE) ? wrt_data     : lat_data;
  assign acc_write   = (state == IDLE) ? we           : lat_write;
  assign acc_rd_also = (state == IDLE) ? re           : lat_rd_also;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (acc_fire) begin
      if (acc_write) begin
        if (acc_rd_also) rd_data <= acc_data;
      end else begin
        rd_data <= mem[acc_idx];
      end
    end
  end

  // Single array write port. The FSM commit and the buffer commit can never
  // coincide: the buffer only fills while the FSM idles without starting.
  always_comb begin
    mem_we   = rst_n & acc_fire & acc_write;
    mem_idx  = acc_idx;
    mem_data = acc_data;
`ifdef DM_POSTED_WRITE_EN
    if (!(acc_fire & acc_write)) begin
      if (buf_commit) begin
        mem_we   = rst_n;
        mem_idx  = buf_idx;
        mem_data = buf_data;
      end else if (direct_post) begin
        mem_we   = rst_n;
        mem_idx  = addr[AW-1:0];
        mem_data = wrt_data;
      end
    end
`endif
  end

  // Array contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_idx] <= mem_data;
  end

endmodule
